// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/WB control FSM with fetch timeout, HALT and FAULT.
// Define CTRL_INSTR_COUNT_EN to build the retired-instruction counter behind instr_count.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_req,
  output logic        ir_load,
  output logic        pc_load,
  output logic        pc_src,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic [5:0]  wa,
  output logic [5:0]  ra1,
  output logic [5:0]  ra2,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0] OP_ADDI = 6'd4, OP_BEQ = 6'd5, OP_HALT = 6'd63;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_WB = 3'd3, S_HALT = 3'd4, S_FAULT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    op_q, op_d, op_a;
  logic [WW-1:0] wait_q, wait_d;
  logic          unused_instr;

  // Immediate and branch-target fields are consumed by the datapath, not here.
  assign unused_instr = ^instr[63:24];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == WW'(TIMEOUT_CYCLES)) begin
            state_d = S_FAULT;
            wait_d  = '0;
          end
        end
      end
      S_DECODE: begin
        op_d = instr[5:0];
        if (instr[5:0] == OP_HALT)     state_d = S_HALT;
        else if (instr[5:0] <= OP_BEQ) state_d = S_EXEC;
        else                           state_d = S_FAULT;
      end
      S_EXEC:  state_d = (op_q == OP_BEQ) ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FAULT;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    alu_op      = 2'd0;
    alu_src_imm = 1'b0;
    wa          = '0;
    ra1         = '0;
    ra2         = '0;
    halted      = 1'b0;
    fault       = 1'b0;
    // op_q is not yet latched during DECODE, so decode addresses from the IR there.
    op_a        = (state_q == S_DECODE) ? instr[5:0] : op_q;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
        end
        S_EXEC: begin
          if (op_q == OP_BEQ) begin
            alu_op  = 2'd1;
            pc_load = 1'b1;
            pc_src  = zero;
          end else begin
            alu_op      = op_q[1:0];
            alu_src_imm = (op_q == OP_ADDI);
          end
        end
        S_WB: begin
          reg_write   = 1'b1;
          pc_load     = 1'b1;
          alu_op      = op_q[1:0];
          alu_src_imm = (op_q == OP_ADDI);
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: ;
      endcase
      if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_WB) begin
        if (op_a <= 6'd3) begin
          wa  = instr[11:6];
          ra1 = instr[17:12];
          ra2 = instr[23:18];
        end else if (op_a == OP_ADDI) begin
          wa  = instr[11:6];
          ra1 = instr[17:12];
        end else if (op_a == OP_BEQ) begin
          ra1 = instr[11:6];
          ra2 = instr[17:12];
        end
      end
    end
  end

  assign state = rst ? 3'd0 : state_q;

`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (state_q == S_WB || (state_q == S_EXEC && op_q == OP_BEQ))
      cnt_q <= cnt_q + 32'd1;
  end

  assign instr_count = rst ? 32'd0 : cnt_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller plus timeout, reset and counter sequences.
module tb_multicycle_controller;
  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] instr = '0;
  logic        mem_ready = 1'b0, zero = 1'b0;
  logic        mem_req, ir_load, pc_load, pc_src, reg_write, alu_src_imm, halted, fault;
  logic [1:0]  alu_op;
  logic [5:0]  wa, ra1, ra2;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int n_tests = 0, n_fail = 0;

`ifdef CTRL_INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  multicycle_controller #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
    .reg_write(reg_write), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .wa(wa), .ra1(ra1), .ra2(ra2), .state(state), .halted(halted), .fault(fault),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [4:0]  en;   // {mem_req, ir_load, pc_load, pc_src, reg_write}
    logic [1:0]  aop;
    logic        imm;
    logic [5:0]  wa, ra1, ra2;
    logic        h, f;
    logic [31:0] cnt;
  } outs_t;

  typedef struct {
    logic        r;
    logic [63:0] in;
    logic        mr, z;
    outs_t       e;
  } vec_t;

  outs_t act;
  assign act = {state, mem_req, ir_load, pc_load, pc_src, reg_write, alu_op, alu_src_imm,
                wa, ra1, ra2, halted, fault, instr_count};

  function automatic outs_t O(input logic [2:0] st, input logic [4:0] en, input logic [1:0] aop,
                              input logic imm, input logic [5:0] a, input logic [5:0] b,
                              input logic [5:0] c, input logic h, input logic f);
    O = {st, en, aop, imm, a, b, c, h, f, 32'd0};
  endfunction

  function automatic vec_t V(input logic r, input logic [63:0] in, input logic mr,
                             input logic z, input outs_t e);
    V = '{r, in, mr, z, e};
  endfunction

  function automatic logic [63:0] I(input int op, input int a, input int b, input int c);
    I = 64'(op) | (64'(a) << 6) | (64'(b) << 12) | (64'(c) << 18);
  endfunction

  task automatic chk(input string name, input logic [62:0] got, input logic [62:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch with memory ready, then walk the instruction back to FETCH.
  task automatic run(input logic [63:0] in, input logic z);
    instr = in; mem_ready = 1'b1; zero = z;
    step();
    mem_ready = 1'b0;
    step();
    step();
    if (in[5:0] != 6'd5) step();
  endtask

  vec_t  v[29];
  outs_t e;
  logic [63:0] ADDI, BEQ, SUB, ORR, ILL, HLT;
  int exp_cnt;

  initial begin
    ADDI = I(4, 3, 1, 9);
    BEQ  = I(5, 7, 2, 11);
    SUB  = I(1, 5, 6, 8);
    ORR  = I(3, 1, 2, 3);
    ILL  = I(7, 1, 2, 3);
    HLT  = I(63, 4, 5, 6);

    v[0]  = V(1, ADDI, 1, 0, O(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    v[1]  = V(0, ADDI, 1, 0, O(0, 5'b11000, 0, 0, 0, 0, 0, 0, 0));
    v[2]  = V(0, ADDI, 0, 0, O(1, 5'b00000, 0, 0, 3, 1, 0, 0, 0));
    v[3]  = V(0, ADDI, 0, 0, O(2, 5'b00000, 0, 1, 3, 1, 0, 0, 0));
    v[4]  = V(0, ADDI, 0, 0, O(3, 5'b00101, 0, 1, 3, 1, 0, 0, 0));
    v[5]  = V(0, BEQ,  0, 0, O(0, 5'b10000, 0, 0, 0, 0, 0, 0, 0));
    v[6]  = V(0, BEQ,  1, 0, O(0, 5'b11000, 0, 0, 0, 0, 0, 0, 0));
    v[7]  = V(0, BEQ,  0, 0, O(1, 5'b00000, 0, 0, 0, 7, 2, 0, 0));
    v[8]  = V(0, BEQ,  0, 1, O(2, 5'b00110, 1, 0, 0, 7, 2, 0, 0));
    v[9]  = V(0, BEQ,  1, 1, O(0, 5'b11000, 0, 0, 0, 0, 0, 0, 0));
    v[10] = V(0, BEQ,  0, 1, O(1, 5'b00000, 0, 0, 0, 7, 2, 0, 0));
    v[11] = V(0, BEQ,  0, 0, O(2, 5'b00100, 1, 0, 0, 7, 2, 0, 0));
    v[12] = V(0, SUB,  1, 0, O(0, 5'b11000, 0, 0, 0, 0, 0, 0, 0));
    v[13] = V(0, SUB,  0, 0, O(1, 5'b00000, 0, 0, 5, 6, 8, 0, 0));
    v[14] = V(0, SUB,  1, 1, O(2, 5'b00000, 1, 0, 5, 6, 8, 0, 0));
    v[15] = V(0, SUB,  0, 0, O(3, 5'b00101, 1, 0, 5, 6, 8, 0, 0));
    v[16] = V(0, ORR,  1, 0, O(0, 5'b11000, 0, 0, 0, 0, 0, 0, 0));
    v[17] = V(0, ORR,  0, 0, O(1, 5'b00000, 0, 0, 1, 2, 3, 0, 0));
    v[18] = V(0, ORR,  0, 0, O(2, 5'b00000, 3, 0, 1, 2, 3, 0, 0));
    v[19] = V(0, ORR,  0, 0, O(3, 5'b00101, 3, 0, 1, 2, 3, 0, 0));
    v[20] = V(0, ILL,  1, 0, O(0, 5'b11000, 0, 0, 0, 0, 0, 0, 0));
    v[21] = V(0, ILL,  0, 0, O(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    v[22] = V(0, ILL,  1, 0, O(5, 5'b00000, 0, 0, 0, 0, 0, 0, 1));
    v[23] = V(0, ILL,  1, 1, O(5, 5'b00000, 0, 0, 0, 0, 0, 0, 1));
    v[24] = V(1, HLT,  1, 0, O(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    v[25] = V(0, HLT,  1, 0, O(0, 5'b11000, 0, 0, 0, 0, 0, 0, 0));
    v[26] = V(0, HLT,  0, 0, O(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0));
    v[27] = V(0, HLT,  1, 0, O(4, 5'b00000, 0, 0, 0, 0, 0, 1, 0));
    v[28] = V(0, HLT,  1, 1, O(4, 5'b00000, 0, 0, 0, 0, 0, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    exp_cnt = 0;
    for (int i = 0; i < 29; i++) begin
      rst = v[i].r; instr = v[i].in; mem_ready = v[i].mr; zero = v[i].z;
      e = v[i].e;
      e.cnt = (CNT_EN && !v[i].r) ? 32'(exp_cnt) : 32'd0;
      #1;
      chk($sformatf("vec%0d", i), act, e);
      step();
      if (v[i].r) exp_cnt = 0;
      else if (e.st == 3'd3 || (e.st == 3'd2 && e.en[2])) exp_cnt++;
    end

    // Fetch timeout: 15 cycles without mem_ready, then sticky FAULT.
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    step();
    rst = 1'b0;
    #1 chk("to_start", {60'd0, state}, 63'd0);
    repeat (14) step();
    chk("to_cycle14", {59'd0, state, mem_req}, {59'd0, 3'd0, 1'b1});
    step();
    chk("to_fault", act, O(5, 5'b00000, 0, 0, 0, 0, 0, 0, 1));
    mem_ready = 1'b1;
    repeat (3) step();
    chk("to_sticky", act, O(5, 5'b00000, 0, 0, 0, 0, 0, 0, 1));

    // Reset held for two cycles while sitting in WB.
    rst = 1'b1;
    step();
    rst = 1'b0; instr = ADDI; mem_ready = 1'b1;
    repeat (3) step();
    chk("wb_reached", {60'd0, state}, 63'd3);
    rst = 1'b1;
    #1 chk("rst_in_wb", act, 63'd0);
    step();
    chk("rst_hold", act, 63'd0);
    step();
    rst = 1'b0;
    #1 chk("rst_release", act, O(0, 5'b11000, 0, 0, 0, 0, 0, 0, 0));

`ifdef CTRL_INSTR_COUNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(I(0, 1, 2, 3), 0);
    run(SUB, 0);
    run(ORR, 0);
    run(BEQ, 1);
    chk("cnt_four", {31'd0, instr_count}, 63'd4);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1 chk("cnt_preload", {31'd0, instr_count}, {31'd0, 32'hFFFF_FFFF});
    run(SUB, 0);
    chk("cnt_wrap", {31'd0, instr_count}, 63'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 15: the maximum number of FETCH cycles without mem_ready before a fault is raised.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 instr  in  64  current instruction-register contents; op=[5:0].
REQ-005 mem_ready  in  1  instruction memory has valid data this cycle.
REQ-006 zero  in  1  ALU zero flag; sampled in EXEC only.
REQ-007 mem_req  out  1  instruction fetch request.
REQ-008 ir_load  out  1  instruction-register load enable.
REQ-009 pc_load  out  1  PC write enable.
REQ-010 pc_src  out  1  PC source: 0 = PC+1, 1 = branch target (instr[33:18]).
REQ-011 reg_write  out  1  register file write enable.
REQ-012 alu_op  out  2  ALU operation: 0 = add, 1 = sub, 2 = and, 3 = or.
REQ-013 alu_src_imm  out  1  ALU operand B source: 1 = imm instr[63:18], 0 = register.
REQ-014 wa, ra1, ra2  out  6 each  register-file write and read addresses.
REQ-015 state  out  3  current state encoding.
REQ-016 halted  out  1  HALT reached.
REQ-017 fault  out  1  FAULT reached.
REQ-018 instr_count  out  32  retired-instruction count (see Configuration).

Function
REQ-019 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4, FAULT=5.
REQ-020 Opcodes SHALL decode as: add=0, sub=1, and=2, or=3, addi=4, beq=5, halt=63; every other opcode is illegal.
REQ-021 FETCH: mem_req=1; when mem_ready=1, ir_load=1 in that same cycle and the next state is DECODE.
REQ-022 FETCH: a wait counter SHALL increment on each cycle with mem_ready=0; when it reaches TIMEOUT_CYCLES, the next state is FAULT; the counter clears on leaving FETCH.
REQ-023 DECODE: op SHALL be latched into op_q. Next state: HALT for op 63, FAULT for an illegal op, otherwise EXEC.
REQ-024 EXEC, R-type (ops 0-3): alu_op=op_q[1:0], alu_src_imm=0; next state WB.
REQ-025 EXEC, addi: alu_op=0, alu_src_imm=1; next state WB.
REQ-026 EXEC, beq: alu_op=1, alu_src_imm=0, pc_load=1, pc_src=zero; next state FETCH.
REQ-027 WB: reg_write=1, pc_load=1, pc_src=0; alu_op and alu_src_imm held at their EXEC values; next state FETCH.
REQ-028 Address mapping SHALL be combinational from instr and op_q:
- R-type: wa=[11:6], ra1=[17:12], ra2=[23:18].
- addi: wa=[11:6], ra1=[17:12], ra2=0.
- beq: ra1=[11:6], ra2=[17:12], wa=0.
- Outside DECODE/EXEC/WB: all addresses 0.
REQ-029 Latency with mem_ready already high: ALU/addi instructions take 4 cycles; beq takes 3 cycles.
REQ-030 mem_ready SHALL be ignored outside FETCH; zero SHALL be ignored outside EXEC.
REQ-031 HALT and FAULT SHALL be sticky until rst; halted=1 in HALT and fault=1 in FAULT; all enables are 0 in both states.
REQ-032 Any output not named as asserted for the current state SHALL be 0.

Reset
REQ-033 rst=1 at a clock edge SHALL force state=FETCH, clear op_q, the wait counter and instr_count, and take effect from any state, including mid-instruction.
REQ-034 While rst=1 all outputs SHALL be 0, including mem_req.

Configuration
REQ-035 Macro CTRL_INSTR_COUNT_EN, when defined, SHALL make instr_count increment by 1 on each WB cycle and each beq EXEC cycle, wrapping from 0xFFFFFFFF to 0.
REQ-036 Without CTRL_INSTR_COUNT_EN, instr_count SHALL be tied to 0 and no counter register is built.

Verification
REQ-037 Reset: hold rst 2 cycles in WB → state=0, all enables 0, instr_count=0.
REQ-038 addi: instr op=4, [11:6]=3, [17:12]=1, mem_ready=1 → ir_load cycle 0; EXEC alu_src_imm=1; WB reg_write=1, wa=3, pc_load=1; back in FETCH at cycle 4.
REQ-039 beq: op=5, zero=1 in EXEC → pc_load=1, pc_src=1, ra1=[11:6], ra2=[17:12]; with zero=0 → pc_src=0.
REQ-040 Timeout: mem_ready held 0 → fault=1 and state=5 after 15 cycles; stays there until rst.
REQ-041 Illegal and halt: op=7 → FAULT after DECODE; op=63 → halted=1, with mem_req=0 thereafter.
REQ-042 Counter (macro defined): 3 R-type instructions plus 1 beq → instr_count=4; preload 0xFFFFFFFF via force → wraps to 0.
